mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer that sits on both sides of the 8:1 mux built from 2:1 muxes.
- Upstream: accepts an 8-bit word over a valid/ready handshake, drives it onto the mux data bus, and steps the 3-bit select through 0..7.
- Downstream: samples the mux output once per select value and reassembles the captured byte.
- Reports the captured byte and a mismatch flag against the driven word, which gives a self-checking scan of the mux path.

Parameters:
- SETTLE_CYCLES, 1, clock cycles to wait after each select change before sampling mux_y; legal range 1..15.
- SEL_W, 3, select width; the number of mux inputs is 2**SEL_W (fixed 8 in this revision).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_data  input  8  word to scan
- in_ready  output  1  block can accept a word
- mux_data  output  8  data bus to the mux
- mux_s2  output  1  mux select MSB
- mux_s1  output  1  mux select mid bit
- mux_s0  output  1  mux select LSB
- mux_y  input  1  mux output (combinational from mux_data/select)
- out_valid  output  1  capture result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  8  reassembled byte
- out_mismatch  output  1  out_data != driven word
- busy  output  1  scan in progress

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready=1; out_valid=0; out_data=0; out_mismatch=0; mux_data=0; select=0; busy=0; settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into mux_data, set select=0, load settle counter with SETTLE_CYCLES-1, clear the capture register, go to SETTLE.
- SETTLE:
  - in_ready=0, busy=1.
  - Counter decrements each cycle; when it is 0, go to SAMPLE on the next edge.
- SAMPLE (one cycle):
  - Capture mux_y into capture[select].
  - If select==7, go to DONE. Otherwise select<=select+1, reload the counter, and go to SETTLE.
- DONE:
  - out_valid=1; out_data=capture; out_mismatch=(capture!=mux_data); busy=0.
  - On out_valid&&out_ready, drop out_valid and return to IDLE. in_ready returns to 1 on the following cycle.
- Select mapping: {mux_s2,mux_s1,mux_s0}=select. The counter increments by 1 and never wraps within a scan; 7 is terminal.
- Scan latency from the accept edge to out_valid=1 is 8*(SETTLE_CYCLES+1) cycles. With SETTLE_CYCLES=1 this is 16 cycles.
- mux_data holds the accepted word stable through SETTLE, SAMPLE and DONE. It changes only on a new accept or on reset.
- in_valid asserted while busy or in DONE is ignored; the word is not queued.
- out_valid held with out_ready low: out_data, out_mismatch and mux_data stay stable indefinitely.
- Reset asserted mid-scan: all state returns to reset values on that edge and the partial capture is discarded.
- X or Z on mux_y at a SAMPLE edge is captured as-is; the bench treats it as a fail.

Optional Feature:
- MUX_SCAN_PARITY_EN defined:
  - Adds output out_parity (1 bit) = XOR of out_data, valid with out_valid.
  - Adds output parity_err = out_parity ^ (XOR of the driven word), same timing.
  - Both outputs reset to 0.
- Undefined: neither port exists and there is no parity logic.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - localparams N_IN=8 and SEL_LAST=3'd7;
  - the 4-bit settle counter width.
- One natural sub-module, mux_scan_settle_timer: loadable down-counter with a zero flag that drives the SETTLE→SAMPLE transition.

Test Plan:
- Word 8'b10100101, ideal 8:1 mux attached, SETTLE_CYCLES=1:
  - select steps 0..7, one step every 2 cycles;
  - out_valid at cycle 16 after accept;
  - out_data=8'hA5, out_mismatch=0.
- Mux model with input 3 stuck-at-0, word 8'hFF: out_data=8'hF7, out_mismatch=1.
- in_valid pulsed again mid-scan with 8'h00: ignored; in_ready=0 during the scan; result still 8'hA5.
- out_ready held low for 10 cycles after DONE:
  - out_valid, out_data and mux_data remain stable;
  - in_ready=0 throughout;
  - accept completes on the first out_ready=1.
- rst asserted at select=4: next edge shows select=0, out_valid=0, in_ready=1, mux_data=0; a following scan of 8'h3C returns 8'h3C.
- With MUX_SCAN_PARITY_EN and SETTLE_CYCLES=3, word 8'h07: latency 32 cycles, out_parity=1, parity_err=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Optional build macro: MUX_SCAN_PARITY_EN (adds parity outputs).
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned N_IN     = 8;
  localparam logic [2:0]  SEL_LAST = 3'd7;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side bus of the scan sequencer.
// master: the sequencer; slave: upstream/downstream/mux environment.
// Optional build macro: MUX_SCAN_PARITY_EN (adds out_parity, parity_err).
interface mux_scan_ctrl_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mux_data;
  logic       mux_s2;
  logic       mux_s1;
  logic       mux_s0;
  logic       mux_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_mismatch;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       out_parity;
  logic       parity_err;
`endif

  modport master (
    input  in_valid, in_data, mux_y, out_ready,
    output in_ready, mux_data, mux_s2, mux_s1, mux_s0,
    output out_valid, out_data, out_mismatch, busy
`ifdef MUX_SCAN_PARITY_EN
    , output out_parity, parity_err
`endif
  );

  modport slave (
    output in_valid, in_data, mux_y, out_ready,
    input  in_ready, mux_data, mux_s2, mux_s1, mux_s0,
    input  out_valid, out_data, out_mismatch, busy
`ifdef MUX_SCAN_PARITY_EN
    , input out_parity, parity_err
`endif
  );

endinterface

// File: rtl/mux_scan_settle_timer.sv
// Loadable down-counter that paces the settle wait after each select change.
module mux_scan_settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around an 8:1 mux: drives a word and walks the select,
// samples the mux output per select, and reports the reassembled byte.
// Optional build macro: MUX_SCAN_PARITY_EN (adds out_parity, parity_err).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SEL_W         = 3
)
(
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        mux_data_q, mux_data_d;
  logic [N_IN-1:0]   cap_q, cap_d, cap_next;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              mismatch_q, mismatch_d;
  logic              tmr_load, tmr_en, tmr_zero_c;
`ifdef MUX_SCAN_PARITY_EN
  logic              parity_q, parity_d;
  logic              parity_err_q, parity_err_d;
`endif

  mux_scan_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .zero_c   (tmr_zero_c)
  );

  // Capture register with the current mux output merged at the select position.
  always_comb begin
    cap_next        = cap_q;
    cap_next[sel_q] = bus.mux_y;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mux_data_q   <= '0;
      cap_q        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      mismatch_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mux_data_q   <= mux_data_d;
      cap_q        <= cap_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mismatch_q   <= mismatch_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mux_data_d   = mux_data_q;
    cap_d        = cap_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    mismatch_d   = mismatch_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = parity_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          mux_data_d = bus.in_data;
          sel_d      = '0;
          cap_d      = '0;
          tmr_load   = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero_c) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      SAMPLE: begin
        cap_d = cap_next;
        if (sel_q == SEL_LAST) begin
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = cap_next;
          mismatch_d  = (cap_next != mux_data_q);
`ifdef MUX_SCAN_PARITY_EN
          parity_d     = ^cap_next;
          parity_err_d = (^cap_next) ^ (^mux_data_q);
`endif
          state_d     = DONE;
        end else begin
          sel_d    = sel_q + SEL_W'(1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready                      = in_ready_q;
  assign bus.busy                          = busy_q;
  assign bus.mux_data                      = mux_data_q;
  assign {bus.mux_s2, bus.mux_s1, bus.mux_s0} = sel_q;
  assign bus.out_valid                     = out_valid_q;
  assign bus.out_data                      = out_data_q;
  assign bus.out_mismatch                  = mismatch_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.out_parity                    = parity_q;
  assign bus.parity_err                    = parity_err_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural 8:1 mux with optional stuck input,
// directed and randomized scans checked against an expected-capture model.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_PARITY_EN
  localparam int unsigned SC = 3;
`else
  localparam int unsigned SC = 1;
`endif
  localparam int unsigned STEP = SC + 1;
  localparam int unsigned LAT  = 8 * STEP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(.SETTLE_CYCLES(SC), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural mux with one optional stuck input.
  logic       fault_en;
  logic [2:0] fault_idx;
  logic       fault_val;
  logic [2:0] tb_sel;

  assign tb_sel    = {bus.mux_s2, bus.mux_s1, bus.mux_s0};
  assign bus.mux_y = (fault_en && (tb_sel == fault_idx)) ? fault_val : bus.mux_data[tb_sel];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte the downstream side should reassemble for a driven word.
  function automatic logic [7:0] ref_capture(input logic [7:0] word);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (fault_en && (fault_idx == 3'(i))) ? fault_val : word[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [7:0] word, input int hold, input bit pulse);
    logic [7:0] exp;
    int k;
    exp = ref_capture(word);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    k = 0;
    while (!bus.out_valid && k < int'(LAT) + 8) begin
      check("sel_step", 32'(tb_sel), 32'(k / int'(STEP)));
      check("in_ready_scan", 32'(bus.in_ready), 32'd0);
      check("busy_scan", 32'(bus.busy), 32'd1);
      check("mux_data_scan", 32'(bus.mux_data), 32'(word));
      if (pulse && k == 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
      end
      if (pulse && k == 7) bus.in_valid = 1'b0;
      tick();
      k++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(k), 32'(LAT));
    check("out_data", 32'(bus.out_data), 32'(exp));
    check("out_mismatch", 32'(bus.out_mismatch), 32'(exp != word));
    check("busy_done", 32'(bus.busy), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("out_parity", 32'(bus.out_parity), 32'(^exp));
    check("parity_err", 32'(bus.parity_err), 32'((^exp) ^ (^word)));
`endif
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(exp));
      check("hold_mux_data", 32'(bus.mux_data), 32'(word));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    fault_en      = 1'b0;
    fault_idx     = 3'd0;
    fault_val     = 1'b0;

    // Reset values.
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_mismatch", 32'(bus.out_mismatch), 32'd0);
    check("rst_mux_data", 32'(bus.mux_data), 32'd0);
    check("rst_sel", 32'(tb_sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // Ideal mux.
    run_scan(8'hA5, 0, 1'b0);

    // Input 3 stuck at 0.
    fault_en  = 1'b1;
    fault_idx = 3'd3;
    fault_val = 1'b0;
    run_scan(8'hFF, 0, 1'b0);
    fault_en  = 1'b0;

    // New word offered mid-scan must be ignored.
    run_scan(8'hA5, 0, 1'b1);

    // Downstream back-pressure.
    run_scan(8'($urandom), 10, 1'b0);

    // Reset in the middle of a scan at select 4.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(4 * STEP); i++) tick();
    check("sel_pre_rst", 32'(tb_sel), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sel", 32'(tb_sel), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_mux_data", 32'(bus.mux_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    run_scan(8'h3C, 0, 1'b0);

    // Low-parity-weight word (parity visible in the parity build).
    run_scan(8'h07, 0, 1'b0);

    // Randomized scans with random faults and back-pressure.
    for (int r = 0; r < 10; r++) begin
      fault_en  = 1'($urandom_range(0, 1));
      fault_idx = 3'($urandom_range(0, 7));
      fault_val = 1'($urandom_range(0, 1));
      run_scan(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    fault_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
